// File: rtl/trgt_sut_upload_buf.sv
// Upload buffer for target-side SUT results: samples {valid, data} plus a sequence tag on
// mission-clock rising edges, queues them, and hands them to the transport put path.
module trgt_sut_upload_buf #(
    parameter int DEPTH         = 4,
    parameter int FREEZE_MARGIN = 1,
    parameter int WDOG_LIMIT    = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clk_mis_h,
    input  logic                     cap_en_i,
    input  logic                     sut_valid_i,
    input  logic [7:0]               sut_data_i,
    output logic                     up_vld_o,
    input  logic                     up_rdy_i,
    output logic [8:0]               up_data_o,
    output logic [7:0]               up_seq_o,
    output logic                     freeze_o,
    output logic                     ovf_err_o,
    output logic                     wdog_err_o,
    input  logic                     err_clr_i,
    input  logic                     flush_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [1:0]               dbg_state_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(WDOG_LIMIT + 1);
    localparam logic [AW-1:0] PTR_ONE   = 1;
    localparam logic [CW-1:0] CNT_ONE   = 1;
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] FREEZE_AT = CW'(DEPTH - FREEZE_MARGIN);
    localparam logic [WW-1:0] WDOG_ONE  = 1;
    localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_LIMIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    logic            clk_mis_d_q;
    logic [7:0]      seq_q;
    logic [16:0]     mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    state_t          state_q;
    logic [WW-1:0]   wdog_q;
    logic            freeze_q;
    logic            ovf_err_q;
    logic            wdog_err_q;
    logic            mis_edge;
    logic            full;
    logic            push;
    logic            pop;
    logic            drop;

    // Handshake: an entry transfers on any clk_i edge where up_vld_o & up_rdy_i; while
    // up_vld_o is high and up_rdy_i low, up_data_o/up_seq_o hold the same head entry.
    assign up_vld_o = (state_q != ST_IDLE);
    assign pop      = up_vld_o & up_rdy_i;
    assign mis_edge = clk_mis_h & ~clk_mis_d_q & cap_en_i;
    assign full     = (count_q == CNT_FULL);
    assign push     = mis_edge & ~flush_i & (~full | pop);
    assign drop     = mis_edge & ~flush_i & full & ~pop;

    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else begin
            count_d = count_q + (push ? CNT_ONE : '0) - (pop ? CNT_ONE : '0);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clk_mis_d_q <= 1'b0;
            seq_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            freeze_q    <= 1'b0;
            ovf_err_q   <= 1'b0;
        end else begin
            clk_mis_d_q <= clk_mis_h;
            count_q     <= count_d;
            freeze_q    <= (count_d >= FREEZE_AT);
            // seq advances on every edge so dropped or flushed samples leave visible gaps
            if (mis_edge) begin
                seq_q <= seq_q + 8'd1;
            end
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
                if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            if (drop) begin
                ovf_err_q <= 1'b1;
            end else if (err_clr_i) begin
                ovf_err_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {sut_valid_i, sut_data_i, seq_q};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            wdog_q     <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            if (err_clr_i) wdog_err_q <= 1'b0;
            if (flush_i) begin
                state_q <= ST_IDLE;
                wdog_q  <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (count_d != '0) state_q <= ST_SEND;
                    end
                    ST_SEND: begin
                        if (pop) begin
                            wdog_q  <= '0;
                            state_q <= (count_d != '0) ? ST_SEND : ST_IDLE;
                        end else if (wdog_q == WDOG_LAST) begin
                            wdog_q     <= wdog_q + WDOG_ONE;
                            state_q    <= ST_STALL;
                            wdog_err_q <= 1'b1;
                        end else begin
                            wdog_q <= wdog_q + WDOG_ONE;
                        end
                    end
                    ST_STALL: begin
                        if (pop) begin
                            wdog_q  <= '0;
                            state_q <= (count_d != '0) ? ST_SEND : ST_IDLE;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        wdog_q  <= '0;
                    end
                endcase
            end
        end
    end

    assign up_data_o   = up_vld_o ? mem_q[rd_ptr_q][16:8] : '0;
    assign up_seq_o    = up_vld_o ? mem_q[rd_ptr_q][7:0]  : '0;
    assign count_o     = count_q;
    assign freeze_o    = freeze_q;
    assign ovf_err_o   = ovf_err_q;
    assign wdog_err_o  = wdog_err_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/trgt_sut_upload_buf.md
Name: trgt_sut_upload_buf

Overview:
Downstream consumer of the target-side SUT outputs. It detects rising edges of one mission clock in the utility-clock domain and captures the SUT result vector {valid, o_data} with a sequence tag into a small FIFO. It presents entries to the transport put path over a valid/ready handshake. It raises a freeze request toward the mission-clock gating when the buffer nears full, and flags overflow and stalled-transport errors.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
FREEZE_MARGIN, 1, freeze_o asserts when occupancy >= DEPTH-FREEZE_MARGIN
WDOG_LIMIT, 8, consecutive stalled cycles before wdog_err

Ports:
clk_i  in  1  utility clock
rst_i  in  1  asynchronous active-high reset
clk_mis_h  in  1  mission clock being observed (level, sampled on clk_i)
cap_en_i  in  1  capture enable
sut_valid_i  in  1  SUT valid
sut_data_i  in  8  SUT o_data
up_vld_o  out  1  entry available to transport
up_rdy_i  in  1  transport accepts entry
up_data_o  out  9  {valid, o_data} of head entry
up_seq_o  out  8  sequence tag of head entry
freeze_o  out  1  request to freeze mission clock
ovf_err_o  out  1  sticky: sample dropped on full
wdog_err_o  out  1  sticky: transport stalled WDOG_LIMIT cycles
err_clr_i  in  1  clears both sticky errors
flush_i  in  1  synchronous FIFO flush
count_o  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset (async, rst_i=1): FIFO empty, count_o=0, seq=0, clk_mis_d=0, up_vld_o=0, up_data_o=0, up_seq_o=0, freeze_o=0, ovf_err_o=0, wdog_err_o=0, watchdog=0, FSM=IDLE. Reset mid-transfer discards all entries with no handshake.
- Edge detect: clk_mis_d <= clk_mis_h every cycle. edge = clk_mis_h & ~clk_mis_d & cap_en_i.
- Capture: on edge, {sut_valid_i, sut_data_i} and the current seq are sampled in the same cycle.
  - If not full (count at cycle start < DEPTH, or a pop occurs in the same cycle), the entry is written.
  - Otherwise the sample is dropped and ovf_err_o <= 1.
  - seq increments modulo 256 on every edge, written or dropped, so gaps are visible downstream (255 -> 0).
- Pop: up_vld_o & up_rdy_i.
  - Push and pop in the same cycle: count unchanged.
  - Push into an empty FIFO: up_vld_o rises the next cycle (no fall-through); edge-to-up_vld_o latency is 1 cycle.
- up_data_o/up_seq_o are stable while up_vld_o=1 and ~up_rdy_i. Output is show-ahead: after a pop, the next entry is presented the following cycle.
- FSM:
  - IDLE: up_vld_o=0. -> SEND when count>0.
  - SEND: up_vld_o=1, watchdog increments each cycle with ~up_rdy_i and resets to 0 on pop. On pop: -> SEND if entries remain (including a same-cycle push), else IDLE. When watchdog reaches WDOG_LIMIT: -> STALL, wdog_err_o <= 1.
  - STALL: up_vld_o=1, watchdog holds. On pop: -> SEND or IDLE as above, watchdog=0. wdog_err_o stays set.
- freeze_o is registered: freeze_o <= (next count >= DEPTH-FREEZE_MARGIN). It deasserts the cycle after occupancy drops below the threshold.
- flush_i:
  - Next cycle: count=0, FSM=IDLE, up_vld_o=0, watchdog=0. seq is not reset.
  - flush_i has priority over a same-cycle push and pop; the pushed sample is discarded without an error.
- err_clr_i clears both sticky errors next cycle. If a new error event occurs in the same cycle, the error is set (set wins).
- cap_en_i=0 blocks edge detection, but clk_mis_d keeps tracking, so enabling while clk_mis_h=1 produces no spurious edge.

Test Plan:
- Reset, then 3 mission edges with data 0x1A5, 0x0FF, 0x100, up_rdy_i=1 -> three pops in order, seq 0,1,2, each up_vld_o 1 cycle after its edge, count returns to 0.
- up_rdy_i=0, 4 edges (DEPTH=4) -> freeze_o=1 after the 3rd push, count=4; 5th edge sets ovf_err_o=1, seq advances to 5, the next entry written carries seq 5.
- up_vld_o=1 with up_rdy_i held 0 for 8 cycles -> wdog_err_o=1, FSM=STALL, data stable; up_rdy_i=1 -> pop, wdog_err_o stays 1 until err_clr_i.
- FIFO full plus a simultaneous edge and pop -> sample accepted, count stays 4, ovf_err_o=0.
- 256 edges with up_rdy_i=1 -> seq wraps 255 -> 0 with no error.
- flush_i with 2 entries and a coincident edge -> count=0, up_vld_o=0 next cycle, seq still incremented. Asserting rst_i mid-SEND -> all outputs at reset values immediately.
